x2c_bcnt_sfifo: RTL
===================

Name: x2c_bcnt_sfifo

Overview:
Parametrised single-clock successor to the 256x32 byte-count FIFO used on the x2c path. It buffers per-packet byte-count words between the packet writer and the byte-count consumer inside one clock domain. It adds selectable show-ahead or normal read mode, almost-full and almost-empty thresholds, and same-cycle read/write arbitration rules. The optional build adds sticky overflow and underflow error flags.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 256, number of entries; must equal 2**PTR
PTR, 8, pointer width in bits
SHOWAHEAD, 0, read mode: 0 = normal (q registered on read), 1 = show-ahead (q presents head entry)
AF_LEVEL, 240, almost_full asserts when usedw >= AF_LEVEL
AE_LEVEL, 16, almost_empty asserts when usedw < AE_LEVEL

Ports:
clock  in  1  the single clock; all logic on rising edge
sclr  in  1  synchronous reset, active-high
wrreq  in  1  write request
data  in  WIDTH  write data
full  out  1  FIFO holds DEPTH entries
almost_full  out  1  usedw >= AF_LEVEL
rdreq  in  1  read request
q  out  WIDTH  read data
empty  out  1  FIFO holds 0 entries
almost_empty  out  1  usedw < AE_LEVEL
usedw  out  PTR+1  current occupancy, 0..DEPTH
ovf  out  1  sticky overflow flag (only with X2C_BCNT_FIFO_ERR_EN)
unf  out  1  sticky underflow flag (only with X2C_BCNT_FIFO_ERR_EN)

Behaviour:
- Reset: one sclr cycle produces the following state. Pointers are 0, usedw=0, empty=1, full=0, almost_empty=1 (AE_LEVEL>0), almost_full=0, q=0 in normal mode, ovf=unf=0. Memory contents are not reset.
- sclr takes priority over wrreq and rdreq in the same cycle. A reset mid-stream discards all stored entries.
- Write acceptance: a write is accepted when wrreq && !full. data is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Read acceptance: a read is accepted when rdreq && !empty. rd_ptr increments, wrapping modulo DEPTH.
- Simultaneous write and read:
  - When both are accepted, usedw and the flags are unchanged.
  - When full, the read is accepted and the write is rejected, so usedw becomes DEPTH-1.
  - When empty, the write is accepted and the read is rejected, so usedw becomes 1.
- Status outputs: usedw, empty, full, almost_full and almost_empty are registered. They are computed from the next occupancy and reflect accepted operations on the following clock edge.
- Write-to-empty latency: 1 clock. empty deasserts on the edge after the accepting write.
- Normal mode (SHOWAHEAD=0): q loads mem[rd_ptr] on the edge of an accepted read, so data is valid 1 clock after rdreq. q holds its value otherwise, including on rejected reads.
- Show-ahead mode (SHOWAHEAD=1): q = mem[rd_ptr] whenever !empty. rdreq acknowledges and pops the entry, and the next entry appears after the edge. q is don't-care while empty.
- Read-during-write at the same address cannot occur, because that only happens when empty and such a read is rejected.
- Arithmetic: usedw is PTR+1 bits and saturates naturally at 0..DEPTH. Pointers are PTR bits and wrap freely.
- Rejected requests leave all state unchanged, apart from ovf/unf in the optional build.

Optional Feature:
X2C_BCNT_FIFO_ERR_EN:
- Defined: ovf and unf ports exist.
  - ovf sets on wrreq && full (after the same-cycle arbitration above).
  - unf sets on rdreq && empty.
  - Both flags are sticky until sclr, and take effect on the next edge.
- Undefined: the ports and their logic are absent, and rejected requests are silently ignored.

Decomposition:
- Package x2c_fifo_pkg holds:
  - the default WIDTH, DEPTH and PTR constants;
  - the SHOWAHEAD mode encodings (X2C_FIFO_NORMAL=0, X2C_FIFO_SHOWAHEAD=1);
  - the default AF/AE levels.
- Sub-module x2c_sfifo_ram is a simple dual-port DEPTHxWIDTH array with one synchronous write port and one read port. The read port is asynchronous for show-ahead and registered for normal mode. Control, pointers and flags stay in x2c_bcnt_sfifo.

Test Plan:
- Reset then fill: sclr 1 cycle, write 0x00000001..0x00000100 (256 writes) -> usedw steps 1..256, almost_full asserts at usedw=240, full=1 after the 256th write. A 257th write is rejected, usedw stays 256, and with ERR_EN ovf=1.
- Drain in normal mode: after the fill, hold rdreq for 256 cycles -> q = 0x00000001..0x00000100, each 1 cycle after its rdreq. empty=1 after the last read. An extra rdreq leaves q=0x00000100, and with ERR_EN unf=1.
- Show-ahead: SHOWAHEAD=1, write 0xA5A5A5A5 -> next cycle empty=0 and q=0xA5A5A5A5 with no rdreq. After rdreq, empty=1.
- Simultaneous operations: at usedw=256, wrreq+rdreq -> usedw=255, full=0. At usedw=0, wrreq+rdreq -> usedw=1, and q is unchanged in normal mode. At usedw=100, wrreq+rdreq -> usedw=100.
- Wrap-around: 1000 cycles of random push/pop keeping usedw<=256 -> read order matches a scoreboard, and the pointers wrap past 255 with no data corruption.
- Reset mid-operation: at usedw=50, assert sclr together with wrreq and rdreq -> next cycle usedw=0, empty=1, almost_empty=1, ovf=unf=0. The first subsequent write reads back correctly.

Source files
------------

// File: rtl/x2c_fifo_pkg.sv
// Shared constants and types for the x2c byte-count FIFO family.
// Holds the default geometry, the read-mode encodings and the flag bundle.
package x2c_fifo_pkg;

  localparam int X2C_FIFO_WIDTH    = 32;
  localparam int X2C_FIFO_DEPTH    = 256;
  localparam int X2C_FIFO_PTR      = 8;
  localparam int X2C_FIFO_AF_LEVEL = 240;
  localparam int X2C_FIFO_AE_LEVEL = 16;

  typedef enum int {
    X2C_FIFO_NORMAL    = 0,
    X2C_FIFO_SHOWAHEAD = 1
  } x2c_fifo_mode_e;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } x2c_fifo_flags_t;

endpackage

// File: rtl/x2c_sfifo_ram.sv
// Simple dual-port DEPTHxWIDTH storage array with one synchronous write port.
// The read port is registered (with read enable) or asynchronous, depending on REG_RD.
module x2c_sfifo_ram
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH  = X2C_FIFO_WIDTH,
  parameter int DEPTH  = X2C_FIFO_DEPTH,
  parameter int PTR    = X2C_FIFO_PTR,
  parameter bit REG_RD = 1'b1
) (
  input  logic             clock_i,
  input  logic             sclr_i,
  input  logic             wr_en_i,
  input  logic [PTR-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [PTR-1:0]   rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch so it maps onto block RAM; stale
  // contents are never observable because the pointers gate every read.
  // NOTE: sequential state is always updated with <= so all flops sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  if (REG_RD) begin : g_reg_rd
    logic [WIDTH-1:0] rd_data_q;

    // Output register is cleared so q reads zero after reset; it holds on idle cycles.
    always_ff @(posedge clock_i) begin
      if (sclr_i) begin
        rd_data_q <= '0;
      end else if (rd_en_i) begin
        rd_data_q <= mem_q[rd_addr_i];
      end
    end

    assign rd_data_o = rd_data_q;
  end else begin : g_async_rd
    assign rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/x2c_bcnt_sfifo.sv
// Single-clock byte-count FIFO with normal/show-ahead read, registered status flags.
// Define X2C_BCNT_FIFO_ERR_EN to add sticky ovf/unf error outputs.
module x2c_bcnt_sfifo
  import x2c_fifo_pkg::*;
#(
  parameter int WIDTH     = X2C_FIFO_WIDTH,
  parameter int DEPTH     = X2C_FIFO_DEPTH,
  parameter int PTR       = X2C_FIFO_PTR,
  parameter int SHOWAHEAD = int'(X2C_FIFO_NORMAL),
  parameter int AF_LEVEL  = X2C_FIFO_AF_LEVEL,
  parameter int AE_LEVEL  = X2C_FIFO_AE_LEVEL
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             almost_full,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     usedw
`ifdef X2C_BCNT_FIFO_ERR_EN
  ,
  output logic             ovf,
  output logic             unf
`endif
);

  localparam logic [PTR:0] DEPTH_CNT = DEPTH[PTR:0];
  localparam logic [PTR:0] AF_CNT    = AF_LEVEL[PTR:0];
  localparam logic [PTR:0] AE_CNT    = AE_LEVEL[PTR:0];
  localparam bit           REG_RD    = (SHOWAHEAD == int'(X2C_FIFO_NORMAL));

  localparam x2c_fifo_flags_t FLAGS_RST = '{
    full:         1'b0,
    almost_full:  (AF_LEVEL == 0),
    empty:        1'b1,
    almost_empty: (AE_LEVEL > 0)
  };

  logic [PTR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR:0]    usedw_q,  usedw_d;
  x2c_fifo_flags_t flags_q,  flags_d;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the registered flags, which resolves the full/empty
  // same-cycle cases: a full FIFO takes only the read, an empty one only the write.
  assign wr_acc = wrreq && !flags_q.full;
  assign rd_acc = rdreq && !flags_q.empty;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase

    flags_d.full         = (usedw_d == DEPTH_CNT);
    flags_d.almost_full  = (usedw_d >= AF_CNT);
    flags_d.empty        = (usedw_d == '0);
    flags_d.almost_empty = (usedw_d < AE_CNT);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      flags_q  <= FLAGS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      flags_q  <= flags_d;
    end
  end

  x2c_sfifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .PTR    (PTR),
    .REG_RD (REG_RD)
  ) u_ram (
    .clock_i   (clock),
    .sclr_i    (sclr),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (q)
  );

  assign usedw        = usedw_q;
  assign full         = flags_q.full;
  assign almost_full  = flags_q.almost_full;
  assign empty        = flags_q.empty;
  assign almost_empty = flags_q.almost_empty;

`ifdef X2C_BCNT_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky until sclr; judged against the same registered flags as acceptance.
  always_ff @(posedge clock) begin
    if (sclr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q || (wrreq && flags_q.full);
      unf_q <= unf_q || (rdreq && flags_q.empty);
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

endmodule
